// File: rtl/i2c_regfile_responder.sv
// i2c_regfile_responder
//   I2C target holding a byte-addressed register file. SCL/SDA are oversampled
//   on Clk_i, START/STOP are decoded, and the 7-bit address I2C_ADDR is answered.
//   Supports pointer-write, burst data-write and data-read transfers. The SDA
//   pad is open-drain: Sda_oe_o=1 pulls the line low.
// Ports
//   Clk_i       system clock, at least 16x SCL
//   Rst_n_i     asynchronous active-low reset (register contents are kept)
//   Scl_i       SCL line sample (never stretched by this target)
//   Sda_i       SDA line sample
//   Sda_oe_o    1 = pull SDA low, 0 = release
//   Hwr_en_i    host-side register write strobe
//   Hwr_addr_i  host-side write address (LSBs used when MEM_SIZE < 256)
//   Hwr_data_i  host-side write data
//   Busy_o      1 from own-address ACK until the next START/STOP
//   Ptr_o       current register pointer (upper bits zero when MEM_SIZE < 256)
module i2c_regfile_responder #(
    parameter logic [6:0]  I2C_ADDR = 7'b001_0000,
    parameter int unsigned MEM_SIZE = 256,
    parameter bit          RD_BURST = 1'b0
) (
    input  logic       Clk_i,
    input  logic       Rst_n_i,
    input  logic       Scl_i,
    input  logic       Sda_i,
    output logic       Sda_oe_o,
    input  logic       Hwr_en_i,
    input  logic [7:0] Hwr_addr_i,
    input  logic [7:0] Hwr_data_i,
    output logic       Busy_o,
    output logic [7:0] Ptr_o
);

    localparam int unsigned AW    = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam logic [7:0]  PMASK = 8'(MEM_SIZE - 1);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK
    } state_t;

    logic [7:0] mem [MEM_SIZE];

    logic [1:0] scl_sync, sda_sync;
    logic       scl_d, sda_d;
    logic       scl_rise, scl_fall, start_det, stop_det, sda_s;

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [7:0] shreg, shreg_n;
    logic [7:0] ptr, ptr_n;
    logic       sda_oe, sda_oe_n;
    logic       busy, busy_n;
    logic       rw, rw_n;
    logic       ack_on, ack_on_n;
    logic       mem_we;
    logic [7:0] shift_in, ptr_inc, rd_byte;

    // 2-FF synchronizers plus one edge-detect stage, idle-high preset
    always_ff @(posedge Clk_i or negedge Rst_n_i) begin
        if (!Rst_n_i) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], Scl_i};
            sda_sync <= {sda_sync[0], Sda_i};
            scl_d    <= scl_sync[1];
            sda_d    <= sda_sync[1];
        end
    end

    assign sda_s     = sda_sync[1];
    assign scl_rise  =  scl_sync[1] & ~scl_d;
    assign scl_fall  = ~scl_sync[1] &  scl_d;
    assign start_det =  scl_sync[1] & scl_d & sda_d & ~sda_s;
    assign stop_det  =  scl_sync[1] & scl_d & ~sda_d & sda_s;

    assign shift_in = {shreg[6:0], sda_s};
    assign ptr_inc  = (ptr + 8'd1) & PMASK;
    assign rd_byte  = mem[ptr[AW-1:0]];

    always_ff @(posedge Clk_i or negedge Rst_n_i) begin
        if (!Rst_n_i) begin
            state  <= IDLE;
            cnt    <= '0;
            shreg  <= '0;
            ptr    <= '0;
            sda_oe <= 1'b0;
            busy   <= 1'b0;
            rw     <= 1'b0;
            ack_on <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            shreg  <= shreg_n;
            ptr    <= ptr_n;
            sda_oe <= sda_oe_n;
            busy   <= busy_n;
            rw     <= rw_n;
            ack_on <= ack_on_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        shreg_n  = shreg;
        ptr_n    = ptr;
        sda_oe_n = sda_oe;
        busy_n   = busy;
        rw_n     = rw;
        ack_on_n = ack_on;
        mem_we   = 1'b0;

        if (stop_det) begin
            state_n  = IDLE;
            cnt_n    = '0;
            sda_oe_n = 1'b0;
            busy_n   = 1'b0;
            ack_on_n = 1'b0;
        end else if (start_det) begin
            state_n  = ADDR;
            cnt_n    = '0;
            sda_oe_n = 1'b0;
            busy_n   = 1'b0;
            ack_on_n = 1'b0;
        end else begin
            unique case (state)
                IDLE: ;
                ADDR, PTR, WDATA: begin
                    if (scl_rise) begin
                        shreg_n = shift_in;
                        cnt_n   = cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            cnt_n = '0;
                            if (state == ADDR) begin
                                rw_n    = sda_s;
                                state_n = (shift_in[7:1] == I2C_ADDR) ? ADDR_ACK : IDLE;
                            end else if (state == PTR) begin
                                ptr_n   = shift_in & PMASK;
                                state_n = PTR_ACK;
                            end else begin
                                mem_we  = 1'b1;
                                ptr_n   = ptr_inc;
                                state_n = WDATA_ACK;
                            end
                        end
                    end
                end
                // First fall after bit 8 asserts ACK, the fall after bit 9 ends it
                ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!ack_on) begin
                            sda_oe_n = 1'b1;
                            ack_on_n = 1'b1;
                            if (state == ADDR_ACK) busy_n = 1'b1;
                        end else begin
                            ack_on_n = 1'b0;
                            sda_oe_n = 1'b0;
                            cnt_n    = '0;
                            if (state == ADDR_ACK && rw) begin
                                shreg_n  = rd_byte;
                                sda_oe_n = ~rd_byte[7];
                                state_n  = RDATA;
                            end else if (state == ADDR_ACK) begin
                                state_n = PTR;
                            end else begin
                                state_n = WDATA;
                            end
                        end
                    end
                end
                // Bit 7 is already on the line on entry; each fall puts out the next
                RDATA: begin
                    if (scl_rise && cnt != 4'd8) begin
                        cnt_n = cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt == 4'd8) begin
                            sda_oe_n = 1'b0;
                            cnt_n    = '0;
                            state_n  = RACK;
                        end else begin
                            sda_oe_n = ~shreg[~cnt[2:0]];
                        end
                    end
                end
                // cnt==1 marks a master ACK seen on the 9th rising edge
                RACK: begin
                    if (scl_rise) begin
                        if (sda_s) begin
                            state_n = IDLE;
                        end else begin
                            cnt_n = 4'd1;
                            if (RD_BURST) ptr_n = ptr_inc;
                        end
                    end else if (scl_fall && cnt == 4'd1) begin
                        shreg_n  = rd_byte;
                        sda_oe_n = ~rd_byte[7];
                        cnt_n    = '0;
                        state_n  = RDATA;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Register file: no reset; an I2C write beats a same-cycle host write
    always_ff @(posedge Clk_i) begin
        if (mem_we) begin
            mem[ptr[AW-1:0]] <= shift_in;
        end else if (Hwr_en_i) begin
            mem[Hwr_addr_i[AW-1:0]] <= Hwr_data_i;
        end
    end

    assign Sda_oe_o = sda_oe;
    assign Busy_o   = busy;
    assign Ptr_o    = ptr;

endmodule

// File: tb/tb_i2c_regfile_responder.sv
// tb_i2c_regfile_responder
//   Bit-banged I2C master driving two responders on one wired-AND bus:
//   dev0 at 0x10 with fixed read pointer, dev1 at 0x12 with read auto-increment.
//   Expected data comes from a byte-array model of both register files.
module tb_i2c_regfile_responder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       hwr_en = 1'b0;
    logic [7:0] hwr_addr = '0;
    logic [7:0] hwr_data = '0;
    logic       oe0, oe1, busy0, busy1, sda_line;
    logic [7:0] ptr0, ptr1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  mm [2][256];
    int unsigned pm [2];

    assign sda_line = sda_m & ~oe0 & ~oe1;

    always #5 clk = ~clk;

    i2c_regfile_responder #(.I2C_ADDR(7'h10), .MEM_SIZE(256), .RD_BURST(1'b0)) dut0 (
        .Clk_i(clk), .Rst_n_i(rst_n), .Scl_i(scl), .Sda_i(sda_line), .Sda_oe_o(oe0),
        .Hwr_en_i(hwr_en), .Hwr_addr_i(hwr_addr), .Hwr_data_i(hwr_data),
        .Busy_o(busy0), .Ptr_o(ptr0));

    i2c_regfile_responder #(.I2C_ADDR(7'h12), .MEM_SIZE(256), .RD_BURST(1'b1)) dut1 (
        .Clk_i(clk), .Rst_n_i(rst_n), .Scl_i(scl), .Sda_i(sda_line), .Sda_oe_o(oe1),
        .Hwr_en_i(hwr_en), .Hwr_addr_i(hwr_addr), .Hwr_data_i(hwr_data),
        .Busy_o(busy1), .Ptr_o(ptr1));

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // ---------------- model ----------------
    function automatic logic [6:0] addr_of(input int dev);
        return (dev == 1) ? 7'h12 : 7'h10;
    endfunction

    function automatic logic [7:0] ptr_of(input int dev);
        return (dev == 1) ? ptr1 : ptr0;
    endfunction

    function automatic void m_wr(input int dev, input logic [7:0] wb[$]);
        if (wb.size() == 0) return;
        pm[dev] = wb[0];
        for (int i = 1; i < wb.size(); i++) begin
            mm[dev][pm[dev]] = wb[i];
            pm[dev] = (pm[dev] + 1) % 256;
        end
    endfunction

    function automatic logic [7:0] m_rd(input int dev, input bit last);
        logic [7:0] d;
        d = mm[dev][pm[dev]];
        if (!last && dev == 1) pm[dev] = (pm[dev] + 1) % 256;
        return d;
    endfunction

    // ---------------- bus primitives ----------------
    task automatic wait_q();
        repeat (4) @(negedge clk);
    endtask

    task automatic bit_xfer(input logic b, output logic r);
        sda_m = b;  wait_q();
        scl = 1'b1; wait_q();
        r = sda_line; wait_q();
        scl = 1'b0; wait_q();
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_q();
        scl = 1'b1;   wait_q();
        sda_m = 1'b0; wait_q();
        scl = 1'b0;   wait_q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_q();
        scl = 1'b1;   wait_q();
        sda_m = 1'b1; wait_q();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
        bit_xfer(1'b1, r);
        ack = ~r;
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, r);
            d[i] = r;
        end
        bit_xfer(nack, r);
    endtask

    task automatic host_wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        hwr_en = 1'b1; hwr_addr = a; hwr_data = d;
        @(negedge clk);
        hwr_en = 1'b0;
        mm[0][a] = d;
        mm[1][a] = d;
    endtask

    // Write phase (address + wb bytes) then optional repeated-START read of nrd bytes
    task automatic xfer(input logic [6:0] a, input logic [7:0] wb[$], input int nrd,
                        output logic [7:0] rb[$], output int nacks, output logic oe_end);
        logic ack;
        logic [7:0] d;
        rb = {};
        nacks = 0;
        i2c_start();
        if (wb.size() > 0 || nrd == 0) begin
            send_byte({a, 1'b0}, ack);
            if (!ack) nacks++;
            foreach (wb[i]) begin
                send_byte(wb[i], ack);
                if (!ack) nacks++;
            end
            if (nrd > 0) i2c_start();
        end
        if (nrd > 0) begin
            send_byte({a, 1'b1}, ack);
            if (!ack) nacks++;
            for (int i = 0; i < nrd; i++) begin
                recv_byte(i == nrd - 1, d);
                rb.push_back(d);
            end
        end
        oe_end = oe0 | oe1;
        i2c_stop();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({oe0, oe1} !== 2'b00) begin
            n_fail++; $display("FAIL reset_oe: got %b expected 00", {oe0, oe1});
        end
        n_checks++;
        if ({busy0, busy1} !== 2'b00) begin
            n_fail++; $display("FAIL reset_busy: got %b expected 00", {busy0, busy1});
        end
        n_checks++;
        if (ptr0 !== 8'h00 || ptr1 !== 8'h00) begin
            n_fail++; $display("FAIL reset_ptr: got %h/%h expected 00/00", ptr0, ptr1);
        end
        rst_n = 1'b1;
        pm[0] = 0;
        pm[1] = 0;
        for (int i = 0; i < 256; i++) host_wr(8'(i), 8'($urandom));
    endtask

    task automatic test_write_spec();
        logic a0, a1, a2, oe;
        logic [7:0] wb[$];
        logic [7:0] rb[$];
        int nk;
        i2c_start();
        send_byte(8'h20, a0);
        n_checks++;
        if (busy0 !== 1'b1) begin
            n_fail++; $display("FAIL write_busy: got %b expected 1", busy0);
        end
        send_byte(8'hF4, a1);
        send_byte(8'h27, a2);
        i2c_stop();
        wb = {8'hF4, 8'h27};
        m_wr(0, wb);
        n_checks++;
        if ({a0, a1, a2} !== 3'b111) begin
            n_fail++; $display("FAIL write_acks: got %b expected 111", {a0, a1, a2});
        end
        n_checks++;
        if (ptr0 !== 8'hF5) begin
            n_fail++; $display("FAIL write_ptr: got %h expected f5", ptr0);
        end
        n_checks++;
        if (busy0 !== 1'b0) begin
            n_fail++; $display("FAIL write_busy_stop: got %b expected 0", busy0);
        end
        wb = {8'hF4};
        xfer(7'h10, wb, 1, rb, nk, oe);
        m_wr(0, wb);
        n_checks++;
        if (rb[0] !== 8'h27 || nk != 0) begin
            n_fail++; $display("FAIL write_readback: got %h nacks %0d expected 27 nacks 0", rb[0], nk);
        end
    endtask

    task automatic test_read_spec();
        logic [7:0] wb[$];
        logic [7:0] rb[$];
        logic [7:0] exp;
        int nk;
        logic oe;
        host_wr(8'hFA, 8'h8A);
        host_wr(8'hFB, 8'h5B);
        host_wr(8'hFC, 8'h12);
        wb = {8'hFA};
        xfer(7'h10, wb, 1, rb, nk, oe);
        m_wr(0, wb);
        exp = m_rd(0, 1'b1);
        n_checks++;
        if (rb[0] !== exp || rb[0] !== 8'h8A) begin
            n_fail++; $display("FAIL read1_data: got %h expected %h", rb[0], exp);
        end
        n_checks++;
        if (oe !== 1'b0) begin
            n_fail++; $display("FAIL read1_release: got oe %b expected 0", oe);
        end
        for (int dev = 0; dev < 2; dev++) begin
            xfer(addr_of(dev), wb, 3, rb, nk, oe);
            m_wr(dev, wb);
            for (int i = 0; i < 3; i++) begin
                exp = m_rd(dev, i == 2);
                n_checks++;
                if (rb[i] !== exp) begin
                    n_fail++; $display("FAIL read3_dev%0d_byte%0d: got %h expected %h", dev, i, rb[i], exp);
                end
            end
            n_checks++;
            if (ptr_of(dev) !== 8'(pm[dev]) || nk != 0) begin
                n_fail++; $display("FAIL read3_dev%0d_ptr: got %h nacks %0d expected %h nacks 0",
                                   dev, ptr_of(dev), nk, 8'(pm[dev]));
            end
        end
    endtask

    task automatic test_addr_mismatch();
        logic ack, oe;
        logic [7:0] rb[$];
        logic [7:0] wb[$];
        int nk;
        i2c_start();
        send_byte(8'h22, ack);
        n_checks++;
        if (ack !== 1'b0 || busy0 !== 1'b0 || busy1 !== 1'b0) begin
            n_fail++; $display("FAIL mismatch_ack_busy: got ack %b busy %b%b expected 0 00", ack, busy0, busy1);
        end
        send_byte(8'h05, ack);
        send_byte(8'h99, ack);
        i2c_stop();
        n_checks++;
        if (ptr0 !== 8'(pm[0]) || ptr1 !== 8'(pm[1])) begin
            n_fail++; $display("FAIL mismatch_ptr: got %h/%h expected %h/%h", ptr0, ptr1, 8'(pm[0]), 8'(pm[1]));
        end
        wb = {8'h05};
        xfer(7'h10, wb, 1, rb, nk, oe);
        m_wr(0, wb);
        n_checks++;
        if (rb[0] !== m_rd(0, 1'b1)) begin
            n_fail++; $display("FAIL mismatch_mem: got %h expected %h", rb[0], mm[0][5]);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] wb[$];
        logic [7:0] rb[$];
        logic [7:0] exp;
        int nk;
        logic oe;
        wb = {8'hFF, 8'($urandom), 8'($urandom)};
        xfer(7'h12, wb, 0, rb, nk, oe);
        m_wr(1, wb);
        n_checks++;
        if (ptr1 !== 8'h01 || nk != 0) begin
            n_fail++; $display("FAIL wrap_ptr: got %h nacks %0d expected 01 nacks 0", ptr1, nk);
        end
        wb = {8'hFF};
        xfer(7'h12, wb, 2, rb, nk, oe);
        m_wr(1, wb);
        for (int i = 0; i < 2; i++) begin
            exp = m_rd(1, i == 1);
            n_checks++;
            if (rb[i] !== exp) begin
                n_fail++; $display("FAIL wrap_byte%0d: got %h expected %h", i, rb[i], exp);
            end
        end
        n_checks++;
        if (ptr1 !== 8'h00) begin
            n_fail++; $display("FAIL wrap_read_ptr: got %h expected 00", ptr1);
        end
    endtask

    task automatic test_host_during_read();
        logic ack, r;
        logic [7:0] p, d, exp, nv;
        p  = 8'($urandom);
        nv = 8'($urandom);
        i2c_start();
        send_byte(8'h20, ack);
        send_byte(p, ack);
        i2c_start();
        send_byte(8'h21, ack);
        pm[0] = p;
        exp = m_rd(0, 1'b1);
        bit_xfer(1'b1, r);
        d[7] = r;
        host_wr(p, nv);
        for (int i = 6; i >= 0; i--) begin
            bit_xfer(1'b1, r);
            d[i] = r;
        end
        bit_xfer(1'b1, r);
        i2c_stop();
        n_checks++;
        if (d !== exp) begin
            n_fail++; $display("FAIL host_shift_byte: got %h expected %h", d, exp);
        end
        n_checks++;
        if (dut0.mem[p] !== nv) begin
            n_fail++; $display("FAIL host_write_landed: got %h expected %h", dut0.mem[p], nv);
        end
    endtask

    task automatic test_malformed();
        logic ack, r, oe;
        logic [7:0] wb[$];
        logic [7:0] rb[$];
        int nk;
        logic [7:0] p;
        p = 8'($urandom);
        i2c_start();
        send_byte(8'h20, ack);
        send_byte(p, ack);
        for (int i = 0; i < 4; i++) bit_xfer(1'($urandom), r);
        i2c_stop();
        pm[0] = p;
        n_checks++;
        if (ptr0 !== p) begin
            n_fail++; $display("FAIL malformed_data_ptr: got %h expected %h", ptr0, p);
        end
        i2c_start();
        send_byte(8'h20, ack);
        for (int i = 0; i < 5; i++) bit_xfer(1'($urandom), r);
        i2c_stop();
        n_checks++;
        if (ptr0 !== p) begin
            n_fail++; $display("FAIL malformed_ptr_ptr: got %h expected %h", ptr0, p);
        end
        wb = {p};
        xfer(7'h10, wb, 1, rb, nk, oe);
        m_wr(0, wb);
        n_checks++;
        if (rb[0] !== m_rd(0, 1'b1)) begin
            n_fail++; $display("FAIL malformed_mem: got %h expected %h", rb[0], mm[0][p]);
        end
    endtask

    task automatic test_reset_mid();
        logic ack, r, oe;
        logic [7:0] p;
        logic [7:0] wb[$];
        logic [7:0] rb[$];
        int nk;
        p = 8'($urandom);
        host_wr(p, 8'h00);
        i2c_start();
        send_byte(8'h20, ack);
        send_byte(p, ack);
        i2c_start();
        send_byte(8'h21, ack);
        for (int i = 0; i < 3; i++) bit_xfer(1'b1, r);
        sda_m = 1'b1;
        wait_q();
        n_checks++;
        if (oe0 !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_driving: got %b expected 1", oe0);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (oe0 !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_release: got %b expected 0", oe0);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        pm[0] = 0;
        pm[1] = 0;
        i2c_stop();
        n_checks++;
        if (busy0 !== 1'b0 || ptr0 !== 8'h00) begin
            n_fail++; $display("FAIL rstmid_state: got busy %b ptr %h expected 0 00", busy0, ptr0);
        end
        wb = {p};
        xfer(7'h10, wb, 1, rb, nk, oe);
        m_wr(0, wb);
        n_checks++;
        if (rb[0] !== m_rd(0, 1'b1) || nk != 0) begin
            n_fail++; $display("FAIL rstmid_after: got %h nacks %0d expected 00 nacks 0", rb[0], nk);
        end
    endtask

    task automatic test_random();
        logic [7:0] wb[$];
        logic [7:0] rb[$];
        logic [7:0] exp;
        int nk, dev, n, nrd;
        logic oe;
        for (int it = 0; it < 16; it++) begin
            dev = $urandom_range(0, 1);
            n   = $urandom_range(0, 3);
            wb  = {8'($urandom)};
            for (int i = 0; i < n; i++) wb.push_back(8'($urandom));
            xfer(addr_of(dev), wb, 0, rb, nk, oe);
            m_wr(dev, wb);
            n_checks++;
            if (nk != 0 || ptr_of(dev) !== 8'(pm[dev])) begin
                n_fail++; $display("FAIL rand%0d_write: got ptr %h nacks %0d expected ptr %h nacks 0",
                                   it, ptr_of(dev), nk, 8'(pm[dev]));
            end
            nrd = $urandom_range(1, 4);
            wb  = {8'($urandom)};
            xfer(addr_of(dev), wb, nrd, rb, nk, oe);
            m_wr(dev, wb);
            for (int i = 0; i < nrd; i++) begin
                exp = m_rd(dev, i == nrd - 1);
                n_checks++;
                if (rb[i] !== exp) begin
                    n_fail++; $display("FAIL rand%0d_dev%0d_byte%0d: got %h expected %h", it, dev, i, rb[i], exp);
                end
            end
            n_checks++;
            if (ptr_of(dev) !== 8'(pm[dev])) begin
                n_fail++; $display("FAIL rand%0d_read_ptr: got %h expected %h", it, ptr_of(dev), 8'(pm[dev]));
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_spec();
        test_read_spec();
        test_addr_mismatch();
        test_wrap();
        test_host_during_read();
        test_malformed();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
